// File: rtl/acc_ctrl_if.sv
// Bundles the job, memory-read and accumulator signals of acc_ctrl.
// master: the controller side; slave: the environment (memory, accumulator, requester).
interface acc_ctrl_if #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 16,
  parameter int unsigned AWIDTH        = 8
);
  // Job request
  logic                     start_i;
  logic [AWIDTH-1:0]        base_addr_i;
  logic [AWIDTH:0]          num_cnt_i;
  // Memory read port
  logic                     mem_ce_o;
  logic [AWIDTH-1:0]        mem_addr_o;
  logic [IN_DATA_WIDTH-1:0] mem_q_i;
  // Accumulator port
  logic                     acc_run_o;
  logic                     acc_valid_o;
  logic [IN_DATA_WIDTH-1:0] acc_number_o;
  logic                     acc_valid_i;
  logic [DWIDTH-1:0]        acc_result_i;
  // Status
  logic                     idle_o;
  logic                     done_o;
  logic [DWIDTH-1:0]        result_o;

  modport master (
    input  start_i, base_addr_i, num_cnt_i, mem_q_i, acc_valid_i, acc_result_i,
    output mem_ce_o, mem_addr_o, acc_run_o, acc_valid_o, acc_number_o, idle_o, done_o,
           result_o
  );

  modport slave (
    output start_i, base_addr_i, num_cnt_i, mem_q_i, acc_valid_i, acc_result_i,
    input  mem_ce_o, mem_addr_o, acc_run_o, acc_valid_o, acc_number_o, idle_o, done_o,
           result_o
  );
endinterface

// File: rtl/acc_ctrl.sv
// Accumulation job controller: streams count operands from memory starting at a base
// address into an external accumulator and captures the final running sum.
module acc_ctrl #(
  parameter int unsigned IN_DATA_WIDTH = 8,
  parameter int unsigned DWIDTH        = 16,
  parameter int unsigned AWIDTH        = 8
) (
  input logic      clk,
  input logic      reset_n,
  acc_ctrl_if.master bus
);

  localparam int unsigned CW = AWIDTH + 1;

  typedef enum logic [2:0] {StIdle, StRun, StRead, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] base_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     rd_cnt_q;   // addresses issued so far
  logic [CW-1:0]     vld_cnt_q;  // accumulator result beats seen so far
  logic              acc_valid_q;
  logic [DWIDTH-1:0] result_q;

  logic              mem_ce;
  logic              rd_last;
  logic              vld_last;
  logic              job_start;

  assign job_start = (state_q == StIdle) && bus.start_i;
  assign rd_last   = (rd_cnt_q == cnt_q - CW'(1));
  assign vld_last  = bus.acc_valid_i && (vld_cnt_q == cnt_q - CW'(1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start_i) state_d = StRun;
      StRun:   state_d = (cnt_q != '0) ? StRead : StDone;
      StRead:  if (rd_last) state_d = StWait;
      StWait:  if (vld_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Job parameters, counters, operand-valid pipeline and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      vld_cnt_q   <= '0;
      acc_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      // Memory data arrives one cycle after the read, so the valid follows ce by one stage
      acc_valid_q <= mem_ce;
      if (job_start) begin
        base_q    <= bus.base_addr_i;
        cnt_q     <= bus.num_cnt_i;
        rd_cnt_q  <= '0;
        vld_cnt_q <= '0;
      end
      if (state_q == StRead) begin
        rd_cnt_q <= rd_cnt_q + CW'(1);
      end
      // Beats in IDLE/DONE are strays from outside a job and are not counted
      if ((state_q == StRun || state_q == StRead || state_q == StWait) && bus.acc_valid_i) begin
        vld_cnt_q <= vld_cnt_q + CW'(1);
      end
      if (state_q == StRun && cnt_q == '0) begin
        result_q <= '0;
      end else if (state_q == StWait && vld_last) begin
        result_q <= bus.acc_result_i;
      end
    end
  end

  // State-decoded outputs
  always_comb begin
    mem_ce        = 1'b0;
    bus.idle_o    = 1'b0;
    bus.done_o    = 1'b0;
    bus.acc_run_o = 1'b0;
    unique case (state_q)
      StIdle:  bus.idle_o    = 1'b1;
      StRun:   bus.acc_run_o = 1'b1;
      StRead:  mem_ce        = 1'b1;
      StWait:  ;
      StDone:  bus.done_o    = 1'b1;
      default: ;
    endcase
  end

  // Address wraps naturally through the AWIDTH-bit add
  assign bus.mem_ce_o     = mem_ce;
  assign bus.mem_addr_o   = base_q + rd_cnt_q[AWIDTH-1:0];
  assign bus.acc_valid_o  = acc_valid_q;
  assign bus.acc_number_o = bus.mem_q_i;
  assign bus.result_o     = result_q;

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: memory and accumulator models attached, scoreboard checks on
// every address, run pulse and done pulse.
module tb_acc_ctrl;
  localparam int IW = 8;
  localparam int DW = 16;
  localparam int AW = 8;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  acc_ctrl_if #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .AWIDTH(AW)) bus ();

  acc_ctrl #(.IN_DATA_WIDTH(IW), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0    = 0;
  int e0_prev = 0;
  int n_done = 0;
  int n_run  = 0;
  bit idle_chk = 1'b0;

  logic [AW-1:0] addr_q[$];
  exp_t          exp_q[$];
  logic [IW-1:0] mem[256];
  logic [DW-1:0] sum;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory with one-cycle read latency
  always @(posedge clk) begin
    if (bus.mem_ce_o) bus.mem_q_i <= mem[bus.mem_addr_o];
  end

  // Accumulator: clears on run, adds each valid operand, returns a beat one cycle later
  always @(posedge clk) begin
    bus.acc_valid_i <= bus.acc_valid_o;
    if (bus.acc_run_o) sum <= '0;
    else if (bus.acc_valid_o) sum <= sum + DW'(bus.acc_number_o);
  end
  assign bus.acc_result_i = sum;

  // Cycle counter and the edge at which each job's start is sampled
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && bus.start_i && bus.idle_o) begin
      e0_prev <= e0;
      e0      <= cyc;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (idle_chk) begin
        check("idle_after_done", int'(bus.idle_o), 1);
        idle_chk = 1'b0;
      end
      if (bus.acc_run_o) begin
        n_run++;
        check("run_cycle", cyc - e0, 1);
      end
      if (bus.mem_ce_o) begin
        if (addr_q.size() == 0) check("unexpected_mem_ce", 1, 0);
        else check("mem_addr", int'(bus.mem_addr_o), int'(addr_q.pop_front()));
      end
      if (bus.done_o) begin
        exp_t e;
        n_done++;
        idle_chk = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result", int'(bus.result_o), e.res);
          check("done_cycle", cyc - e0, e.cyc);
          check("idle_in_done", int'(bus.idle_o), 0);
        end
      end
    end
  end

  task automatic issue(input int base, input int cnt, input int res);
    exp_t e;
    for (int i = 0; i < cnt; i++) addr_q.push_back(AW'(base + i));
    e.res = res;
    e.cyc = (cnt == 0) ? 2 : cnt + 4;
    exp_q.push_back(e);
  endtask

  task automatic start_job(input int base, input int cnt, input int res);
    issue(base, cnt, res);
    bus.base_addr_i = AW'(base);
    bus.num_cnt_i   = (AW + 1)'(cnt);
    bus.start_i     = 1'b1;
    @(negedge clk); #1;
    bus.start_i     = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (n_done < target) check("done_timeout", n_done, target);
  endtask

  task automatic run_job(input int base, input int cnt, input int res);
    int tgt;
    tgt = n_done + 1;
    start_job(base, cnt, res);
    wait_done(tgt, cnt + 20);
    @(negedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, int'(bus.idle_o), 1);
    check({tag, "_done"}, int'(bus.done_o), 0);
    check({tag, "_acc_run"}, int'(bus.acc_run_o), 0);
    check({tag, "_acc_valid"}, int'(bus.acc_valid_o), 0);
    check({tag, "_mem_ce"}, int'(bus.mem_ce_o), 0);
    check({tag, "_mem_addr"}, int'(bus.mem_addr_o), 0);
    check({tag, "_result"}, int'(bus.result_o), 0);
  endtask

  initial begin
    int runs0;
    int dones0;
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.num_cnt_i   = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;
    @(negedge clk); #1;

    // base 0x10, operands 1..4
    mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd3; mem[8'h13] = 8'd4;
    run_job('h10, 4, 10);

    // Empty job: one run pulse, no reads, result forced to zero
    runs0 = n_run;
    run_job('h10, 0, 0);
    check("cnt0_run_pulses", n_run - runs0, 1);

    // Address wrap at the top of memory
    mem[8'hFE] = 8'd7; mem[8'hFF] = 8'd8; mem[8'h00] = 8'd9; mem[8'h01] = 8'd10;
    run_job('hFE, 4, 34);

    // Full-depth job, all operands 0xFF
    for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
    run_job('h00, 256, 65280);

    // start held high across two count=3 jobs
    mem[8'h20] = 8'd3; mem[8'h21] = 8'd4; mem[8'h22] = 8'd5;
    runs0 = n_run;
    dones0 = n_done;
    issue('h20, 3, 12);
    issue('h20, 3, 12);
    bus.base_addr_i = 8'h20;
    bus.num_cnt_i   = 9'd3;
    bus.start_i     = 1'b1;
    wait_done(dones0 + 2, 40);
    bus.start_i     = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("held_start_run_pulses", n_run - runs0, 2);
    check("held_start_job_spacing", e0 - e0_prev, 8);

    // Reset in the middle of a count=8 read phase
    start_job('h40, 8, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("pre_reset_mem_ce", int'(bus.mem_ce_o), 1);
    dones0 = n_done;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midjob");
    addr_q.delete();
    exp_q.delete();
    @(negedge clk); #1;
    @(negedge clk); #1;
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk); #1;
    end
    check("abort_no_done", n_done - dones0, 0);
    check("abort_idle", int'(bus.idle_o), 1);

    // First job after reset
    mem[8'h50] = 8'd5; mem[8'h51] = 8'd6;
    run_job('h50, 2, 11);
    check("result_hold", int'(bus.result_o), 11);
    check("queues_drained", addr_q.size() + exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
